// File: rtl/alu_arbiter_if.sv
// ---------------------------------------------------------------------------
// alu_arbiter_if
// Purpose: bundles the two requester channels and the single tagged response
//          channel of alu_arbiter.
// Signals:
//   req0_valid/req0_ready/req0_a/req0_b/req0_op : requester port 0
//   req1_valid/req1_ready/req1_a/req1_b/req1_op : requester port 1
//   rsp_valid/rsp_ready                         : response handshake
//   rsp_id/rsp_r/rsp_flags/rsp_err              : response payload
// Modports:
//   master : issue side (drives requests, consumes responses)
//   slave  : arbiter side
// ---------------------------------------------------------------------------
interface alu_arbiter_if #(
  parameter int WIDTH = 32,
  parameter int OPW   = 4
);
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic [OPW-1:0]   req0_op;

  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic [OPW-1:0]   req1_op;

  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_r;
  logic [3:0]       rsp_flags;
  logic             rsp_err;

  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    input  req0_ready,
    output req1_valid, req1_a, req1_b, req1_op,
    input  req1_ready,
    input  rsp_valid, rsp_id, rsp_r, rsp_flags, rsp_err,
    output rsp_ready
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    output req0_ready,
    input  req1_valid, req1_a, req1_b, req1_op,
    output req1_ready,
    output rsp_valid, rsp_id, rsp_r, rsp_flags, rsp_err,
    input  rsp_ready
  );
endinterface

// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
// Purpose: shares one combinational 32-bit alu between two requesters.
//          A request is captured into operand registers, executed for one
//          cycle, and the registered result/flags are returned on a single
//          response channel tagged with the requester id. One op in flight.
// Ports:
//   clk   : clock, all state updates on posedge
//   rst_n : synchronous active-low reset
//   bus   : alu_arbiter_if.slave (two request ports + response channel)
// Optional feature:
//   ALU_ARB_OVF_TRAP_EN - when defined, signed add/sub overflow returns
//   rsp_r=0 with rsp_err=1 (flags still come from the alu).
// Also contains module alu: the combinational alu owned by the arbiter.
// ---------------------------------------------------------------------------

// alu: combinational, flags are {zero, carry, negative, overflow}.
//   carry = carry-out for addu/add, borrow for subu/sub, a<b for sltu.
//   overflow = signed overflow for add/sub only.
//   Illegal codes (1000/1001) give r=0, so flags read 4'b1000.
module alu #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       aluc,
  output logic [WIDTH-1:0] r,
  output logic             zero,
  output logic             carry,
  output logic             negative,
  output logic             overflow
);
  logic [WIDTH:0]   sum_s;
  logic [WIDTH:0]   dif_s;
  logic [4:0]       shamt_s;
  logic             slt_s;
  logic             sltu_s;

  assign sum_s   = {1'b0, a} + {1'b0, b};
  assign dif_s   = {1'b0, a} - {1'b0, b};
  assign shamt_s = a[4:0];
  assign slt_s   = ($signed(a) < $signed(b));
  assign sltu_s  = (a < b);

  // Operation decode: result, carry and overflow per aluc code.
  always_comb begin
    r        = '0;
    carry    = 1'b0;
    overflow = 1'b0;
    case (aluc)
      4'b0000: begin
        r     = sum_s[WIDTH-1:0];
        carry = sum_s[WIDTH];
      end
      4'b0010: begin
        r        = sum_s[WIDTH-1:0];
        carry    = sum_s[WIDTH];
        overflow = (a[WIDTH-1] == b[WIDTH-1]) && (sum_s[WIDTH-1] != a[WIDTH-1]);
      end
      4'b0001: begin
        r     = dif_s[WIDTH-1:0];
        carry = dif_s[WIDTH];
      end
      4'b0011: begin
        r        = dif_s[WIDTH-1:0];
        carry    = dif_s[WIDTH];
        overflow = (a[WIDTH-1] != b[WIDTH-1]) && (dif_s[WIDTH-1] != a[WIDTH-1]);
      end
      4'b0100: r = a & b;
      4'b0101: r = a | b;
      4'b0110: r = a ^ b;
      4'b0111: r = ~(a | b);
      4'b1011: r = {{(WIDTH-1){1'b0}}, slt_s};
      4'b1010: begin
        r     = {{(WIDTH-1){1'b0}}, sltu_s};
        carry = sltu_s;
      end
      4'b1110, 4'b1111: r = b << shamt_s;
      4'b1101: r = b >> shamt_s;
      4'b1100: r = $signed(b) >>> shamt_s;
      default: r = '0;
    endcase
  end

  assign zero     = (r == '0);
  assign negative = r[WIDTH-1];
endmodule

module alu_arbiter #(
  parameter int WIDTH = 32,
  parameter int OPW   = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  alu_arbiter_if.slave  bus
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_s;

  // last_grant_r = 1 means port 0 wins the next contended cycle.
  logic             last_grant_r;
  logic             grant0_s;
  logic             grant1_s;
  logic             accept_s;

  logic [WIDTH-1:0] op_a_r;
  logic [WIDTH-1:0] op_b_r;
  logic [OPW-1:0]   op_code_r;
  logic             op_id_r;

  logic [WIDTH-1:0] alu_r_s;
  logic             alu_zero_s;
  logic             alu_carry_s;
  logic             alu_neg_s;
  logic             alu_ovf_s;

  logic [WIDTH-1:0] res_s;
  logic             err_s;
  logic             illegal_s;

  logic             rsp_valid_r;
  logic             rsp_id_r;
  logic [WIDTH-1:0] rsp_r_r;
  logic [3:0]       rsp_flags_r;
  logic             rsp_err_r;

  // Round-robin grant; only offered in IDLE and never while reset is asserted.
  always_comb begin
    grant0_s = 1'b0;
    grant1_s = 1'b0;
    if ((state_r == IDLE) && rst_n) begin
      if (bus.req0_valid && bus.req1_valid) begin
        if (last_grant_r) begin
          grant0_s = 1'b1;
        end else begin
          grant1_s = 1'b1;
        end
      end else if (bus.req0_valid) begin
        grant0_s = 1'b1;
      end else if (bus.req1_valid) begin
        grant1_s = 1'b1;
      end else begin
        grant0_s = 1'b0;
      end
    end else begin
      grant0_s = 1'b0;
    end
  end

  assign accept_s       = grant0_s | grant1_s;
  assign bus.req0_ready = grant0_s;
  assign bus.req1_ready = grant1_s;

  // Next-state logic for the IDLE -> EXEC -> RESP sequence.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_s = EXEC;
        end else begin
          state_s = IDLE;
        end
      end
      EXEC: state_s = RESP;
      RESP: begin
        if (bus.rsp_ready) begin
          state_s = IDLE;
        end else begin
          state_s = RESP;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Operand capture on request handshake; the alu only ever sees these.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_a_r       <= '0;
      op_b_r       <= '0;
      op_code_r    <= '0;
      op_id_r      <= 1'b0;
      last_grant_r <= 1'b1;
    end else if (accept_s) begin
      op_a_r       <= grant1_s ? bus.req1_a  : bus.req0_a;
      op_b_r       <= grant1_s ? bus.req1_b  : bus.req0_b;
      op_code_r    <= grant1_s ? bus.req1_op : bus.req0_op;
      op_id_r      <= grant1_s;
      last_grant_r <= grant1_s;
    end else begin
      last_grant_r <= last_grant_r;
    end
  end

  alu #(.WIDTH(WIDTH)) u_alu (
    .a        (op_a_r),
    .b        (op_b_r),
    .aluc     (op_code_r[3:0]),
    .r        (alu_r_s),
    .zero     (alu_zero_s),
    .carry    (alu_carry_s),
    .negative (alu_neg_s),
    .overflow (alu_ovf_s)
  );

  assign illegal_s = (op_code_r[3:0] == 4'b1000) || (op_code_r[3:0] == 4'b1001);

  // Result/error selection, including the optional overflow trap.
  always_comb begin
    res_s = alu_r_s;
    err_s = illegal_s;
`ifdef ALU_ARB_OVF_TRAP_EN
    if (((op_code_r[3:0] == 4'b0010) || (op_code_r[3:0] == 4'b0011)) && alu_ovf_s) begin
      res_s = '0;
      err_s = 1'b1;
    end else begin
      res_s = alu_r_s;
    end
`endif
  end

  // Response registers: loaded at the end of EXEC, held until consumed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid_r <= 1'b0;
      rsp_id_r    <= 1'b0;
      rsp_r_r     <= '0;
      rsp_flags_r <= 4'b0000;
      rsp_err_r   <= 1'b0;
    end else if (state_r == EXEC) begin
      rsp_valid_r <= 1'b1;
      rsp_id_r    <= op_id_r;
      rsp_r_r     <= res_s;
      rsp_flags_r <= {alu_zero_s, alu_carry_s, alu_neg_s, alu_ovf_s};
      rsp_err_r   <= err_s;
    end else if ((state_r == RESP) && bus.rsp_ready) begin
      rsp_valid_r <= 1'b0;
    end else begin
      rsp_valid_r <= rsp_valid_r;
    end
  end

  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_id    = rsp_id_r;
  assign bus.rsp_r     = rsp_r_r;
  assign bus.rsp_flags = rsp_flags_r;
  assign bus.rsp_err   = rsp_err_r;
endmodule

// File: tb/tb_alu_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_arbiter: directed self-checking bench for alu_arbiter.
// Inputs are driven and outputs sampled at the negedge; posedge is active.
// ---------------------------------------------------------------------------
module tb_alu_arbiter;
  logic clk;
  logic rst_n;
  int   pass_cnt;
  int   chk_cnt;

  alu_arbiter_if #(.WIDTH(32), .OPW(4)) bus_if ();

  alu_arbiter #(.WIDTH(32), .OPW(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_rsp(input int max_cycles, output bit ok);
    int n;
    n = 0;
    while (!bus_if.rsp_valid && n < max_cycles) begin
      tick();
      n++;
    end
    ok = bus_if.rsp_valid;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    bus_if.req0_valid = 1'b0;
    bus_if.req1_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bus_if.req0_valid = 1'b1;
    bus_if.req0_op = 4'b0000;
    tick();
    tick();
    #1;
    chk_cnt++;
    if (bus_if.req0_ready !== 1'b0) $display("FAIL reset_ready0: got %b want 0", bus_if.req0_ready); else pass_cnt++;
    chk_cnt++;
    if ({bus_if.rsp_valid, bus_if.rsp_id, bus_if.rsp_err} !== 3'b000)
      $display("FAIL reset_rsp_ctl: got %b want 000", {bus_if.rsp_valid, bus_if.rsp_id, bus_if.rsp_err}); else pass_cnt++;
    chk_cnt++;
    if (bus_if.rsp_r !== 32'h0000_0000) $display("FAIL reset_rsp_r: got %h want 0", bus_if.rsp_r); else pass_cnt++;
    chk_cnt++;
    if (bus_if.rsp_flags !== 4'b0000) $display("FAIL reset_flags: got %b want 0000", bus_if.rsp_flags); else pass_cnt++;
    bus_if.req0_valid = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_add_overflow;
    logic [31:0] exp_r;
    logic        exp_err;
`ifdef ALU_ARB_OVF_TRAP_EN
    exp_r = 32'h0000_0000;
    exp_err = 1'b1;
`else
    exp_r = 32'hf000_0000;
    exp_err = 1'b0;
`endif
    bus_if.rsp_ready = 1'b1;
    bus_if.req0_valid = 1'b1;
    bus_if.req0_a = 32'h7fff_ffff;
    bus_if.req0_b = 32'h7000_0001;
    bus_if.req0_op = 4'b0010;
    #1;
    chk_cnt++;
    if (bus_if.req0_ready !== 1'b1) $display("FAIL add_ready: got %b want 1", bus_if.req0_ready); else pass_cnt++;
    tick();
    bus_if.req0_valid = 1'b0;
    chk_cnt++;
    if (bus_if.rsp_valid !== 1'b0) $display("FAIL add_lat_exec: got %b want 0", bus_if.rsp_valid); else pass_cnt++;
    tick();
    chk_cnt++;
    if (bus_if.rsp_valid !== 1'b1) $display("FAIL add_lat_resp: got %b want 1", bus_if.rsp_valid); else pass_cnt++;
    chk_cnt++;
    if (bus_if.rsp_id !== 1'b0) $display("FAIL add_id: got %b want 0", bus_if.rsp_id); else pass_cnt++;
    chk_cnt++;
    if (bus_if.rsp_r !== exp_r) $display("FAIL add_r: got %h want %h", bus_if.rsp_r, exp_r); else pass_cnt++;
    chk_cnt++;
    if (bus_if.rsp_flags !== 4'b0011) $display("FAIL add_flags: got %b want 0011", bus_if.rsp_flags); else pass_cnt++;
    chk_cnt++;
    if (bus_if.rsp_err !== exp_err) $display("FAIL add_err: got %b want %b", bus_if.rsp_err, exp_err); else pass_cnt++;
    tick();
    chk_cnt++;
    if (bus_if.rsp_valid !== 1'b0) $display("FAIL add_rsp_done: got %b want 0", bus_if.rsp_valid); else pass_cnt++;
  endtask

  task automatic test_both_valid;
    bit ok;
    do_reset();
    bus_if.rsp_ready = 1'b0;
    bus_if.req0_valid = 1'b1;
    bus_if.req0_a = 32'hffff_ffff;
    bus_if.req0_b = 32'hffff_ffff;
    bus_if.req0_op = 4'b0001;
    bus_if.req1_valid = 1'b1;
    bus_if.req1_a = 32'hf000_1231;
    bus_if.req1_b = 32'h7ac3_4545;
    bus_if.req1_op = 4'b1010;
    #1;
    chk_cnt++;
    if ({bus_if.req0_ready, bus_if.req1_ready} !== 2'b10)
      $display("FAIL both_grant0: got %b want 10", {bus_if.req0_ready, bus_if.req1_ready}); else pass_cnt++;
    tick();
    bus_if.req0_valid = 1'b0;
    #1;
    chk_cnt++;
    if (bus_if.req1_ready !== 1'b0) $display("FAIL both_exec_ready1: got %b want 0", bus_if.req1_ready); else pass_cnt++;
    wait_rsp(4, ok);
    chk_cnt++;
    if (!ok) $display("FAIL both_rsp0_timeout: got no rsp_valid want rsp_valid=1"); else pass_cnt++;
    chk_cnt++;
    if ({bus_if.rsp_id, bus_if.rsp_r, bus_if.rsp_flags} !== {1'b0, 32'h0000_0000, 4'b1000})
      $display("FAIL both_rsp0: got id=%b r=%h f=%b want id=0 r=0 f=1000", bus_if.rsp_id, bus_if.rsp_r, bus_if.rsp_flags); else pass_cnt++;
    bus_if.rsp_ready = 1'b1;
    tick();
    #1;
    chk_cnt++;
    if (bus_if.req1_ready !== 1'b1) $display("FAIL both_grant1: got %b want 1", bus_if.req1_ready); else pass_cnt++;
    tick();
    bus_if.req1_valid = 1'b0;
    wait_rsp(4, ok);
    chk_cnt++;
    if (!ok) $display("FAIL both_rsp1_timeout: got no rsp_valid want rsp_valid=1"); else pass_cnt++;
    chk_cnt++;
    if ({bus_if.rsp_id, bus_if.rsp_r, bus_if.rsp_flags} !== {1'b1, 32'h0000_0000, 4'b1000})
      $display("FAIL both_rsp1: got id=%b r=%h f=%b want id=1 r=0 f=1000", bus_if.rsp_id, bus_if.rsp_r, bus_if.rsp_flags); else pass_cnt++;
    tick();
  endtask

  task automatic test_back_to_back;
    bit ok;
    logic        exp_id;
    logic [31:0] exp_r;
    bus_if.rsp_ready = 1'b1;
    bus_if.req0_valid = 1'b1;
    bus_if.req0_a = 32'd10;
    bus_if.req0_b = 32'd20;
    bus_if.req0_op = 4'b0000;
    bus_if.req1_valid = 1'b1;
    bus_if.req1_a = 32'hff00_ff00;
    bus_if.req1_b = 32'h0ff0_0ff0;
    bus_if.req1_op = 4'b0110;
    for (int k = 0; k < 4; k++) begin
      exp_id = (k % 2 == 1);
      exp_r = exp_id ? 32'hf0f0_f0f0 : 32'h0000_001e;
      wait_rsp(4, ok);
      chk_cnt++;
      if (!ok) $display("FAIL rr_timeout_%0d: got no rsp_valid want rsp_valid=1", k); else pass_cnt++;
      chk_cnt++;
      if (bus_if.rsp_id !== exp_id) $display("FAIL rr_id_%0d: got %b want %b", k, bus_if.rsp_id, exp_id); else pass_cnt++;
      chk_cnt++;
      if (bus_if.rsp_r !== exp_r) $display("FAIL rr_r_%0d: got %h want %h", k, bus_if.rsp_r, exp_r); else pass_cnt++;
      tick();
    end
    bus_if.req0_valid = 1'b0;
    bus_if.req1_valid = 1'b0;
  endtask

  task automatic test_backpressure;
    bit ok;
    bus_if.rsp_ready = 1'b0;
    bus_if.req0_valid = 1'b1;
    bus_if.req0_a = 32'd3;
    bus_if.req0_b = 32'hffff_ffff;
    bus_if.req0_op = 4'b1100;
    tick();
    bus_if.req0_a = 32'd0;
    bus_if.req0_op = 4'b0000;
    bus_if.req1_valid = 1'b1;
    wait_rsp(4, ok);
    chk_cnt++;
    if (!ok) $display("FAIL bp_timeout: got no rsp_valid want rsp_valid=1"); else pass_cnt++;
    chk_cnt++;
    if (bus_if.rsp_flags !== 4'b0010) $display("FAIL bp_flags: got %b want 0010", bus_if.rsp_flags); else pass_cnt++;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk_cnt++;
      if ({bus_if.rsp_valid, bus_if.rsp_r} !== {1'b1, 32'hffff_ffff})
        $display("FAIL bp_hold_%0d: got v=%b r=%h want v=1 r=ffffffff", c, bus_if.rsp_valid, bus_if.rsp_r); else pass_cnt++;
      chk_cnt++;
      if ({bus_if.req0_ready, bus_if.req1_ready} !== 2'b00)
        $display("FAIL bp_ready_%0d: got %b want 00", c, {bus_if.req0_ready, bus_if.req1_ready}); else pass_cnt++;
      tick();
    end
    bus_if.req0_valid = 1'b0;
    bus_if.req1_valid = 1'b0;
    bus_if.rsp_ready = 1'b1;
    tick();
    chk_cnt++;
    if (bus_if.rsp_valid !== 1'b0) $display("FAIL bp_release: got %b want 0", bus_if.rsp_valid); else pass_cnt++;
  endtask

  task automatic test_illegal_reset;
    bit ok;
    bus_if.rsp_ready = 1'b1;
    bus_if.req0_valid = 1'b1;
    bus_if.req0_a = 32'd5;
    bus_if.req0_b = 32'd6;
    bus_if.req0_op = 4'b1000;
    tick();
    bus_if.req0_valid = 1'b0;
    wait_rsp(4, ok);
    chk_cnt++;
    if (!ok) $display("FAIL ill_timeout: got no rsp_valid want rsp_valid=1"); else pass_cnt++;
    chk_cnt++;
    if ({bus_if.rsp_err, bus_if.rsp_r, bus_if.rsp_flags} !== {1'b1, 32'h0000_0000, 4'b1000})
      $display("FAIL ill_rsp: got err=%b r=%h f=%b want err=1 r=0 f=1000", bus_if.rsp_err, bus_if.rsp_r, bus_if.rsp_flags); else pass_cnt++;
    tick();
    // port 0 again so that port 1 would win the next contended cycle
    bus_if.req0_valid = 1'b1;
    bus_if.req0_op = 4'b0000;
    tick();
    bus_if.req0_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    chk_cnt++;
    if (bus_if.rsp_valid !== 1'b0) $display("FAIL rst_exec_valid: got %b want 0", bus_if.rsp_valid); else pass_cnt++;
    rst_n = 1'b1;
    tick();
    chk_cnt++;
    if (bus_if.rsp_valid !== 1'b0) $display("FAIL rst_dropped: got %b want 0", bus_if.rsp_valid); else pass_cnt++;
    bus_if.req0_valid = 1'b1;
    bus_if.req1_valid = 1'b1;
    #1;
    chk_cnt++;
    if ({bus_if.req0_ready, bus_if.req1_ready} !== 2'b10)
      $display("FAIL rst_grant0: got %b want 10", {bus_if.req0_ready, bus_if.req1_ready}); else pass_cnt++;
    tick();
    bus_if.req0_valid = 1'b0;
    bus_if.req1_valid = 1'b0;
    wait_rsp(4, ok);
    chk_cnt++;
    if (!ok || bus_if.rsp_id !== 1'b0) $display("FAIL rst_rsp_id: got ok=%b id=%b want ok=1 id=0", ok, bus_if.rsp_id); else pass_cnt++;
    tick();
  endtask

  task automatic test_capture;
    bit ok;
    bus_if.rsp_ready = 1'b1;
    bus_if.req1_valid = 1'b1;
    bus_if.req1_a = 32'd5;
    bus_if.req1_b = 32'hffff_ffff;
    bus_if.req1_op = 4'b1110;
    tick();
    bus_if.req1_valid = 1'b0;
    bus_if.req1_a = 32'd0;
    bus_if.req1_b = 32'h0000_0000;
    bus_if.req1_op = 4'b0101;
    wait_rsp(4, ok);
    chk_cnt++;
    if (!ok) $display("FAIL cap_timeout: got no rsp_valid want rsp_valid=1"); else pass_cnt++;
    chk_cnt++;
    if ({bus_if.rsp_id, bus_if.rsp_r, bus_if.rsp_flags, bus_if.rsp_err} !== {1'b1, 32'hffff_ffe0, 4'b0010, 1'b0})
      $display("FAIL cap_rsp: got id=%b r=%h f=%b e=%b want id=1 r=ffffffe0 f=0010 e=0",
               bus_if.rsp_id, bus_if.rsp_r, bus_if.rsp_flags, bus_if.rsp_err); else pass_cnt++;
    tick();
  endtask

  initial begin
    pass_cnt = 0;
    chk_cnt = 0;
    rst_n = 1'b0;
    bus_if.req0_valid = 1'b0;
    bus_if.req0_a = 32'h0000_0000;
    bus_if.req0_b = 32'h0000_0000;
    bus_if.req0_op = 4'b0000;
    bus_if.req1_valid = 1'b0;
    bus_if.req1_a = 32'h0000_0000;
    bus_if.req1_b = 32'h0000_0000;
    bus_if.req1_op = 4'b0000;
    bus_if.rsp_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_add_overflow();
    test_both_valid();
    test_back_to_back();
    test_backpressure();
    test_illegal_reset();
    test_capture();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
